fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the pipelined MIPS core, sitting directly upstream of the decode/control unit. Owns the PC, drives the registered-read instruction memory (address in cycle N, data valid in cycle N+1), absorbs in-flight returns in a small skid FIFO while decode stalls, and produces the IF/ID pipeline register. Branch/jump redirects from downstream flush all fetched-but-unconsumed instructions.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; word aligned.
- `BUF_DEPTH`, default 2: skid FIFO entries; minimum 2, since the memory has 1 cycle of read latency.

- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_addr`  out  32: fetch address; equals current PC.
- `imem_rd_en`  out  1: fetch request this cycle.
- `imem_data`  in  32: instruction for the request issued in the previous cycle.
- `redirect`  in  1: taken branch or jump; flush and reload the PC.
- `redirect_pc`  in  32: new PC; bits [1:0] forced to 0.
- `id_stall`  in  1: decode does not accept the IF/ID contents this cycle.
- `if_id_valid`  out  1: IF/ID register holds a live instruction.
- `if_id_instr`  out  32: fetched instruction.
- `if_id_pc_plus4`  out  32: address of `if_id_instr` + 4.

## Operation
- State:
  - `pc` (32)
  - `inflight` (1 bit, plus the issued PC)
  - FIFO of {instr, pc_plus4} × BUF_DEPTH with `count`
  - IF/ID register
- Issue rule: `imem_rd_en = !rst && !redirect && (count + inflight < BUF_DEPTH)`.
  - When asserted, `pc <= pc + 4`, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - `inflight <= imem_rd_en` every cycle.
- Return: when `inflight`, `imem_data` is valid and is tagged with the issued PC + 4.
- IF/ID load condition: `!if_id_valid || !id_stall`. Source priority:
  - FIFO head (pop).
  - Otherwise the current return (bypass).
  - Otherwise `if_id_valid <= 0`.
- A return that is not bypassed is pushed to the FIFO. Order is strictly program order.
- The issue rule guarantees no push into a full FIFO and no dropped return; never drop, never overwrite.
- IF/ID holds its value (valid stays 1) while `id_stall` && `if_id_valid`.
- Redirect, which has priority over all other events including `id_stall`:
  - `pc <= {redirect_pc[31:2],2'b00}`
  - FIFO `count <= 0`
  - `if_id_valid <= 0`
  - the in-flight return is squashed (not pushed, not bypassed)
  - `imem_rd_en = 0` in the redirect cycle
- Reset values: `pc = RESET_PC`, `count = 0`, `inflight = 0`, `if_id_valid = 0`, `if_id_instr = 0`, `if_id_pc_plus4 = 0`, `imem_rd_en = 0`. Reset mid-operation discards everything, identical to power-up.

## Timing
- Cycle 0 is the first cycle after `rst` deasserts: `imem_addr = RESET_PC`, `imem_rd_en = 1`.
  - Cycle 1: data returns and is bypassed.
  - Cycle 2: `if_id_valid = 1` with that instruction.
  - Fetch-to-IF/ID latency: 2 cycles.
- Steady state without stall: one instruction per cycle, FIFO empty.
- Stall onset: at most BUF_DEPTH returns are buffered; `imem_rd_en` drops once `count + inflight` reaches BUF_DEPTH.
- Stall release: the FIFO drains one entry per cycle with no bubble, and issue resumes in the same cycle space frees.
- Redirect in cycle R:
  - Fetch of the target is issued in R+1.
  - The target instruction is valid in IF/ID from R+3.
  - Cycles R+1 and R+2 show `if_id_valid = 0`.
- Redirect and `rst` both high: reset wins.

## Configuration
- `FETCH_STALL_CNT_EN` defined: adds output `stall_cycles` (32 bits).
  - Increments, saturating at 32'hFFFF_FFFF, every cycle with `if_id_valid && id_stall && !redirect`.
  - Reset to 0 by `rst`.
- Not defined: the port and counter do not exist; behaviour is otherwise identical.

## Test plan
- Reset release, memory word at address A = 32'h0000_0004·k, no stall:
  - Expect `imem_addr` 0, 4, 8… on consecutive cycles.
  - Expect `if_id_instr` of word 0 with `if_id_pc_plus4 = 4` at cycle 2, then one per cycle.
- Hold `id_stall` 5 cycles from cycle 4:
  - IF/ID frozen.
  - `imem_rd_en` low after 2 buffered.
  - On release, the next instructions appear in order with no gap and no duplicate.
- `redirect = 1`, `redirect_pc = 32'h0000_0102` while the FIFO holds 2 entries and a fetch is in flight:
  - Buffered and in-flight instructions never reach IF/ID.
  - Next `imem_addr = 32'h0000_0100` one cycle later.
  - IF/ID valid with word at 0x100 three cycles after the redirect.
- Redirect and `id_stall` in the same cycle: `if_id_valid = 0` next cycle.
- PC wrap: redirect to 32'hFFFF_FFF8. Expect `imem_addr` FFF8, FFFC, 0000_0000; `if_id_pc_plus4` for FFFC is 0.
- Assert `rst` mid-stall with a full FIFO: next cycle all outputs hold their reset values, and fetch restarts at `RESET_PC`.
  - With `FETCH_STALL_CNT_EN`, `stall_cycles` reads 0 after reset and counts exactly the stalled-valid cycles in the stall scenario (5).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, registered-read imem request, skid FIFO and IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   issued_pc4;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc4   [BUF_DEPTH];
  logic [CW-1:0] count;

  logic [CW:0]   occupancy;
  logic          fifo_empty;
  logic          ret_valid;
  logic          load;
  logic          pop;
  logic          push;
  logic [CW-1:0] wr_pos;
  logic [IW-1:0] wr_idx;

  always_comb begin
    occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_rd_en = !rst && !redirect && (occupancy < (CW+1)'(BUF_DEPTH));
    imem_addr  = pc;
    fifo_empty = (count == '0);
    // A return arriving during a redirect belongs to the squashed path.
    ret_valid  = inflight && !redirect;
    load       = !if_id_valid || !id_stall;
    pop        = !redirect && load && !fifo_empty;
    push       = ret_valid && !(load && fifo_empty);
    wr_pos     = pop ? (count - CW'(1)) : count;
    wr_idx     = IW'(wr_pos);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      issued_pc4 <= 32'h0;
    end else begin
      inflight <= imem_rd_en;
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (imem_rd_en) begin
        pc         <= pc + 32'd4;
        issued_pc4 <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head lives at index 0; popping shifts the remaining entries down.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        buf_instr[i] <= buf_instr[i+1];
        buf_pc4[i]   <= buf_pc4[i+1];
      end
    end
    if (push) begin
      buf_instr[wr_idx] <= imem_data;
      buf_pc4[wr_idx]   <= issued_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
    end else if (load) begin
      if (!fifo_empty) begin
        if_id_valid    <= 1'b1;
        if_id_instr    <= buf_instr[0];
        if_id_pc_plus4 <= buf_pc4[0];
      end else if (ret_valid) begin
        if_id_valid    <= 1'b1;
        if_id_instr    <= imem_data;
        if_id_pc_plus4 <= issued_pc4;
      end else begin
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'h0;
    end else if (if_id_valid && id_stall && !redirect && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycle table, decode-side monitor pops expected instructions.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_data      (imem_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Registered-read memory: data for the previous cycle's request.
  always @(posedge clk) imem_data <= imem_rd_en ? word(imem_addr) : 32'hDEAD_BEEF;

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.instr = word(a);
    e.pc4   = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
    @(posedge clk);
    #1;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    id_stall    = st;
    #1;
  endtask

  // Decode side: an instruction is consumed when valid, not stalled and not flushed.
  always @(negedge clk) begin
    if (!rst && if_id_valid && !id_stall && !redirect) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr actual=%h/%h required=none", if_id_instr, if_id_pc_plus4);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (if_id_instr !== e.instr || if_id_pc_plus4 !== e.pc4) begin
          miscompares++;
          $display("FAIL consumed_instr actual=%h/%h required=%h/%h",
                   if_id_instr, if_id_pc_plus4, e.instr, e.pc4);
        end
      end
    end
  end

  initial begin
    logic        r, rd, st;
    logic [31:0] rpc;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;

    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("reset_valid", {31'b0, if_id_valid}, 32'h0);
    chk("reset_instr", if_id_instr, 32'h0);
    chk("reset_pc4", if_id_pc_plus4, 32'h0);
    chk("reset_rd_en", {31'b0, imem_rd_en}, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);

    for (int c = 0; c < 38; c++) begin
      r   = (c == 30 || c == 31);
      st  = (c >= 4 && c <= 8) || (c == 14 || c == 15) || (c >= 28 && c <= 31);
      rd  = (c == 15 || c == 21);
      rpc = (c == 15) ? 32'h0000_0102 : ((c == 21) ? 32'hFFFF_FFF8 : 32'h0);
      case (c)
        0:  for (int k = 0; k < 7; k++) push_exp(32'(k * 4));
        16: begin push_exp(32'h100); push_exp(32'h104); push_exp(32'h108); end
        22: begin push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4); end
        32: for (int k = 0; k < 4; k++) push_exp(32'(k * 4));
        default: ;
      endcase
      cyc(r, rd, rpc, st);
      case (c)
        0: begin chk("c0_addr", imem_addr, 32'h0); chk("c0_rd_en", {31'b0, imem_rd_en}, 32'h1); end
        1: begin chk("c1_addr", imem_addr, 32'h4); chk("c1_valid", {31'b0, if_id_valid}, 32'h0); end
        2: begin
          chk("c2_valid", {31'b0, if_id_valid}, 32'h1);
          chk("c2_instr", if_id_instr, word(32'h0));
          chk("c2_pc4", if_id_pc_plus4, 32'h4);
        end
        4: begin chk("c4_addr", imem_addr, 32'h10); chk("c4_rd_en", {31'b0, imem_rd_en}, 32'h1); end
        5: begin chk("c5_rd_en", {31'b0, imem_rd_en}, 32'h0); chk("c5_frozen", if_id_instr, word(32'h8)); end
        8: begin
          chk("c8_rd_en", {31'b0, imem_rd_en}, 32'h0);
          chk("c8_frozen", if_id_instr, word(32'h8));
          chk("c8_valid", {31'b0, if_id_valid}, 32'h1);
        end
        9: begin
          chk("c9_rd_en", {31'b0, imem_rd_en}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
          chk("c9_stall_cycles", stall_cycles, 32'd5);
`endif
        end
        10: begin
          chk("c10_rd_en", {31'b0, imem_rd_en}, 32'h1);
          chk("c10_addr", imem_addr, 32'h14);
          chk("c10_instr", if_id_instr, word(32'hC));
        end
        15: chk("c15_rd_en", {31'b0, imem_rd_en}, 32'h0);
        16: begin
          chk("c16_valid", {31'b0, if_id_valid}, 32'h0);
          chk("c16_addr", imem_addr, 32'h100);
          chk("c16_rd_en", {31'b0, imem_rd_en}, 32'h1);
        end
        17: chk("c17_valid", {31'b0, if_id_valid}, 32'h0);
        18: begin
          chk("c18_valid", {31'b0, if_id_valid}, 32'h1);
          chk("c18_instr", if_id_instr, word(32'h100));
          chk("c18_pc4", if_id_pc_plus4, 32'h104);
        end
        22: chk("c22_addr", imem_addr, 32'hFFFF_FFF8);
        23: chk("c23_addr", imem_addr, 32'hFFFF_FFFC);
        24: begin
          chk("c24_addr", imem_addr, 32'h0);
          chk("c24_instr", if_id_instr, word(32'hFFFF_FFF8));
        end
        25: chk("c25_wrap_pc4", if_id_pc_plus4, 32'h0);
        31: begin
          chk("rst_mid_valid", {31'b0, if_id_valid}, 32'h0);
          chk("rst_mid_instr", if_id_instr, 32'h0);
          chk("rst_mid_pc4", if_id_pc_plus4, 32'h0);
          chk("rst_mid_rd_en", {31'b0, imem_rd_en}, 32'h0);
          chk("rst_mid_addr", imem_addr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
          chk("rst_mid_stall_cycles", stall_cycles, 32'd0);
`endif
        end
        32: begin chk("c32_addr", imem_addr, 32'h0); chk("c32_rd_en", {31'b0, imem_rd_en}, 32'h1); end
        34: begin
          chk("c34_valid", {31'b0, if_id_valid}, 32'h1);
          chk("c34_instr", if_id_instr, word(32'h0));
          chk("c34_pc4", if_id_pc_plus4, 32'h4);
        end
        default: ;
      endcase
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
